// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and framing helpers for the async serial link
package serial_pkg;
  localparam int MAX_BITS = 64;
  typedef enum logic [2:0] {
    S_READY,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_BREAK_HOLD
  } t_tx_state;
  function automatic t_tx_state next_phase(input t_tx_state s, input int start_bits,
                                           input int parity_bits, input int stop_bits);
    case (s)
      S_READY:  return start_bits > 0 ? S_START : S_DATA;
      S_START:  return S_DATA;
      S_DATA:   return parity_bits > 0 ? S_PARITY : stop_bits > 0 ? S_STOP : S_READY;
      S_PARITY: return stop_bits > 0 ? S_STOP : S_READY;
      default:  return S_READY;
    endcase
  endfunction
  function automatic logic calc_parity(input logic [MAX_BITS-1:0] word, input logic even);
    return even ? ^word : ~^word;
  endfunction
endpackage

// File: rtl/serial_baud_tick.sv
// serial_baud_tick: one-cycle tick every MAIN_CLK_HZ/SERIAL_CLK_HZ cycles, held at zero by in_clear
module serial_baud_tick
  import serial_pkg::*;
#(
  parameter int MAIN_CLK_HZ   = 50_000_000,
  parameter int SERIAL_CLK_HZ = 9_600
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clear,
  output logic out_tick
);
  localparam int BIT_CYCLES = MAIN_CLK_HZ / SERIAL_CLK_HZ;
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  if (BIT_CYCLES < 2) begin : g_bad_ratio
    $error("serial_baud_tick: MAIN_CLK_HZ / SERIAL_CLK_HZ must be at least 2");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  assign out_tick = cnt_q == CW'(BIT_CYCLES - 1);
  // wrap on the tick, stay at zero while cleared
  always_comb cnt_d = (in_clear || out_tick) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_async_tx.sv
// serial_async_tx: UART-style transmitter, start/data/parity/stop framing on a baud-tick enable
// Optional line-break generation is enabled by defining SERIAL_TX_BREAK_EN (adds in_break).
module serial_async_tx
  import serial_pkg::*;
#(
  parameter int   MAIN_CLK_HZ   = 50_000_000,
  parameter int   SERIAL_CLK_HZ = 9_600,
  parameter int   BITS          = 8,
  parameter int   START_BITS    = 1,
  parameter int   PARITY_BITS   = 0,
  parameter int   STOP_BITS     = 1,
  parameter logic LOWBIT_FIRST  = 1'b1,
  parameter logic EVEN_PARITY   = 1'b1,
  parameter logic SERIAL_START  = 1'b0,
  parameter logic SERIAL_STOP   = 1'b1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_enable,
  input  logic [BITS-1:0] in_parallel,
`ifdef SERIAL_TX_BREAK_EN
  input  logic            in_break,
`endif
  output logic            out_serial,
  output logic            out_ready,
  output logic            out_next_word,
  output logic            out_word_finished
);
  localparam int M1 = BITS > START_BITS ? BITS : START_BITS;
  localparam int M2 = PARITY_BITS > STOP_BITS ? PARITY_BITS : STOP_BITS;
  localparam int MAXC = M1 > M2 ? M1 : M2;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW = BITS > 1 ? $clog2(BITS) : 1;
  t_tx_state state_q, state_d, nxt;
  logic [CW-1:0] bit_q, bit_d;
  logic [BITS-1:0] word_q, word_d;
  logic [IW-1:0] idx;
  logic par_q, par_d, serial_q, serial_d, next_word_q, next_word_d;
  logic tick, clear, in_frame, last_bit, start_frame, adv;
  function automatic int phase_len(input t_tx_state s);
    return s == S_START ? START_BITS : s == S_PARITY ? PARITY_BITS : s == S_STOP ? STOP_BITS : BITS;
  endfunction
  assign clear = state_q inside {S_READY, S_BREAK};
  assign in_frame = state_q inside {S_START, S_DATA, S_PARITY, S_STOP};
  assign last_bit = bit_q == CW'(phase_len(state_q) - 1);
  assign out_serial = serial_q;
  assign out_ready = state_q == S_READY;
  assign out_next_word = next_word_q;
  assign out_word_finished = tick && state_q == S_DATA && last_bit;
  serial_baud_tick #(
    .MAIN_CLK_HZ  (MAIN_CLK_HZ),
    .SERIAL_CLK_HZ(SERIAL_CLK_HZ)
  ) u_baud (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_clear(clear),
    .out_tick(tick)
  );
  // phase sequencing; the line level is derived from the next state so it changes on the same edge
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    word_d = word_q;
    par_d = par_q;
    adv = 1'b0;
    nxt = next_phase(state_q, START_BITS, PARITY_BITS, STOP_BITS);
    start_frame = state_q == S_READY && in_enable;
    if (in_frame && tick) begin
      adv = 1'b1;
      if (!last_bit) bit_d = bit_q + 1'b1;
      else begin
        bit_d = '0;
        state_d = nxt;
        start_frame = nxt == S_READY && in_enable;
      end
    end
`ifdef SERIAL_TX_BREAK_EN
    if (state_q == S_READY && in_break) begin
      start_frame = 1'b0;
      state_d = S_BREAK;
    end
    if (state_q == S_BREAK && !in_break) state_d = S_BREAK_HOLD;
    if (state_q == S_BREAK_HOLD && tick) state_d = S_READY;
`endif
    if (start_frame) begin
      word_d = in_parallel;
      par_d = calc_parity(MAX_BITS'(in_parallel), EVEN_PARITY);
      state_d = next_phase(S_READY, START_BITS, PARITY_BITS, STOP_BITS);
      bit_d = '0;
      adv = 1'b1;
    end
    idx = LOWBIT_FIRST ? IW'(bit_d) : IW'(BITS - 1) - IW'(bit_d);
    serial_d = state_d == S_START ? SERIAL_START :
               state_d == S_DATA ? word_d[idx] :
               state_d == S_PARITY ? par_d :
               state_d == S_BREAK ? ~SERIAL_STOP : SERIAL_STOP;
    next_word_d = adv && state_d == S_DATA && bit_d == CW'(BITS - 1);
  end
  // state, counters, latched word and registered line
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) begin
      state_q <= S_READY;
      bit_q <= '0;
      word_q <= '0;
      par_q <= 1'b0;
      serial_q <= SERIAL_STOP;
      next_word_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      word_q <= word_d;
      par_q <= par_d;
      serial_q <= serial_d;
      next_word_q <= next_word_d;
    end
endmodule

// File: tb/tb_serial_async_tx.sv
// tb_serial_async_tx: directed scoreboard bench; DUT0 8N1 LSB-first, DUT1 8E1 LSB-first, DUT2 8O1 MSB-first
module tb_serial_async_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] en = '0;
  logic [7:0] par = '0;
`ifdef SERIAL_TX_BREAK_EN
  logic brk = 1'b0;
`endif
  logic [2:0] ser, rdy, nw, wf;
  int tests = 0;
  int fails = 0;
  typedef struct packed {logic lvl; logic last;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;

  serial_async_tx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000)) dut0 (
    .in_clk(clk), .in_rst(rst), .in_enable(en[0]), .in_parallel(par),
`ifdef SERIAL_TX_BREAK_EN
    .in_break(brk),
`endif
    .out_serial(ser[0]), .out_ready(rdy[0]), .out_next_word(nw[0]), .out_word_finished(wf[0]));
  serial_async_tx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000), .PARITY_BITS(1),
                    .EVEN_PARITY(1'b1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_enable(en[1]), .in_parallel(par),
`ifdef SERIAL_TX_BREAK_EN
    .in_break(brk),
`endif
    .out_serial(ser[1]), .out_ready(rdy[1]), .out_next_word(nw[1]), .out_word_finished(wf[1]));
  serial_async_tx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000), .PARITY_BITS(1),
                    .EVEN_PARITY(1'b0), .LOWBIT_FIRST(1'b0)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_enable(en[2]), .in_parallel(par),
`ifdef SERIAL_TX_BREAK_EN
    .in_break(brk),
`endif
    .out_serial(ser[2]), .out_ready(rdy[2]), .out_next_word(nw[2]), .out_word_finished(wf[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input int d, input logic [7:0] w);
    logic p;
    p = (d == 1) ? ^w : ~^w;
    q.push_back({1'b0, 1'b0});
    for (int i = 0; i < 8; i++) q.push_back({(d == 2) ? w[7-i] : w[i], i == 7});
    if (d != 0) q.push_back({p, 1'b0});
    q.push_back({1'b1, 1'b0});
  endtask

  task automatic start(input int d, input logic [7:0] w);
    @(negedge clk);
    par = w;
    en[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_bits(input int d, input int n, input logic keep, input logic swap,
                            input logic [7:0] sv);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL scoreboard_empty observed=0 expected=>0");
        return;
      end
      e = q.pop_front();
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("serial%0d_bit%0d_cyc%0d", d, i, k), ser[d], e.lvl);
        chk($sformatf("ready_busy%0d", d), rdy[d], 1'b0);
        chk($sformatf("next_word%0d_bit%0d_cyc%0d", d, i, k), nw[d], e.last && k == 0);
        chk($sformatf("word_finished%0d_bit%0d_cyc%0d", d, i, k), wf[d], e.last && k == 9);
        if (!keep) en = '0;
        if (swap && nw[d]) par = sv;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input int d);
    chk($sformatf("idle_ready%0d", d), rdy[d], 1'b1);
    chk($sformatf("idle_serial%0d", d), ser[d], 1'b1);
    chk($sformatf("idle_next_word%0d", d), nw[d], 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_serial%0d", d), ser[d], 1'b1);
      chk($sformatf("rst_ready%0d", d), rdy[d], 1'b1);
      chk($sformatf("rst_next_word%0d", d), nw[d], 1'b0);
      chk($sformatf("rst_word_finished%0d", d), wf[d], 1'b0);
    end
    rst = 1'b0;
    push_frame(0, 8'hA5);
    start(0, 8'hA5);
    check_bits(0, q.size(), 1'b0, 1'b0, 8'h00);
    check_idle(0);
    push_frame(1, 8'h07);
    start(1, 8'h07);
    check_bits(1, q.size(), 1'b0, 1'b0, 8'h00);
    check_idle(1);
    push_frame(2, 8'h07);
    start(2, 8'h07);
    check_bits(2, q.size(), 1'b0, 1'b0, 8'h00);
    check_idle(2);
    push_frame(2, 8'h80);
    start(2, 8'h80);
    check_bits(2, q.size(), 1'b0, 1'b0, 8'h00);
    check_idle(2);
    push_frame(0, 8'h55);
    push_frame(0, 8'hAA);
    start(0, 8'h55);
    check_bits(0, 10, 1'b1, 1'b1, 8'hAA);
    check_bits(0, 10, 1'b0, 1'b0, 8'h00);
    check_idle(0);
    push_frame(0, 8'h3C);
    start(0, 8'h3C);
    check_bits(0, 4, 1'b0, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_rst_serial", ser[0], 1'b1);
    chk("midframe_rst_ready", rdy[0], 1'b1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_frame(0, 8'hC3);
    start(0, 8'hC3);
    check_bits(0, q.size(), 1'b0, 1'b0, 8'h00);
    check_idle(0);
`ifdef SERIAL_TX_BREAK_EN
    @(negedge clk);
    brk = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("break_low_cyc%0d", k), ser[0], 1'b0);
      chk($sformatf("break_ready_cyc%0d", k), rdy[0], 1'b0);
      if (k == 24) brk = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("break_hold_cyc%0d", k), ser[0], 1'b1);
      chk($sformatf("break_hold_ready_cyc%0d", k), rdy[0], 1'b0);
      @(negedge clk);
    end
    check_idle(0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
